// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 custom instructions (read and write side).
package lcd_pkg;

  localparam int T_AS_DEF     = 3;
  localparam int T_EN_DEF     = 15;
  localparam int T_HOLD_DEF   = 2;
  localparam int T_GAP_DEF    = 10;
  localparam int POLL_MAX_DEF = 4096;

  localparam int TIMER_W = 8;

  typedef logic [2:0] state_t;
  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_SETUP = 3'd1;
  localparam state_t S_PULSE = 3'd2;
  localparam state_t S_HOLD  = 3'd3;
  localparam state_t S_GAP   = 3'd4;
  localparam state_t S_DONE  = 3'd5;

  localparam int RES_BYTE    = 0;
  localparam int RES_TIMEOUT = 8;
  localparam int ARG_RS      = 0;
  localparam int ARG_POLL    = 1;

endpackage

// File: rtl/lcd_reader_if.sv
// Custom-instruction handshake plus LCD pin group of the LCD read instruction.
interface lcd_reader_if;
  logic        clk_en;
  logic        start;
  logic [31:0] dataa;
  logic        done;
  logic [31:0] result;
  logic [7:0]  lcd_data_in;
  logic        busy;
  logic        rw;
  logic        rs;
  logic        en;

  modport master (
    output clk_en, start, dataa, lcd_data_in,
    input  done, result, busy, rw, rs, en
  );

  modport slave (
    input  clk_en, start, dataa, lcd_data_in,
    output done, result, busy, rw, rs, en
  );
endinterface

// File: rtl/lcd_phase_timer.sv
// Loadable down-counter timing each bus phase; holds at zero and freezes with clk_en.
module lcd_phase_timer
  import lcd_pkg::*;
#(
  parameter int W = TIMER_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clk_en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clk_en) begin
      if (load)
        cnt <= load_val;
      else if (cnt != '0)
        cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/lcd_reader.sv
// Multi-cycle custom instruction performing HD44780 read cycles, single or BF-poll.
module lcd_reader
  import lcd_pkg::*;
#(
  parameter int T_AS     = T_AS_DEF,
  parameter int T_EN     = T_EN_DEF,
  parameter int T_HOLD   = T_HOLD_DEF,
  parameter int T_GAP    = T_GAP_DEF,
  parameter int POLL_MAX = POLL_MAX_DEF
) (
  input logic         clk,
  input logic         reset_n,
  lcd_reader_if.slave bus
);

  localparam int CW = $clog2(POLL_MAX + 1);
  localparam logic [CW-1:0] POLL_LIM = CW'(POLL_MAX);

  state_t             state;
  state_t             next_state;
  logic [CW-1:0]      poll_cnt;
  logic               poll_q;
  logic               rs_q;
  logic [8:0]         res_q;
  logic               en_q;
  logic               rw_q;
  logic               busy_q;
  logic               done_q;
  logic               t_zero;
  logic               t_load;
  logic [TIMER_W-1:0] t_val;
  logic               last_pulse;
  logic               unused_dataa;

  assign unused_dataa = ^bus.dataa[31:2];
  assign last_pulse   = (state == S_PULSE) && t_zero;

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (bus.start) next_state = S_SETUP;
      S_SETUP: if (t_zero) next_state = S_PULSE;
      S_PULSE: if (t_zero) next_state = S_HOLD;
      S_HOLD:
        if (t_zero) begin
          if (poll_q && res_q[RES_BYTE+7] && poll_cnt < POLL_LIM)
            next_state = S_GAP;
          else
            next_state = S_DONE;
        end
      S_GAP:   if (t_zero) next_state = S_SETUP;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Every state change reloads the timer with the length of the phase being entered
  always_comb begin
    t_load = (next_state != state);
    case (next_state)
      S_SETUP: t_val = TIMER_W'(T_AS - 1);
      S_PULSE: t_val = TIMER_W'(T_EN - 1);
      S_HOLD:  t_val = TIMER_W'(T_HOLD - 1);
      S_GAP:   t_val = TIMER_W'(T_GAP - 1);
      default: t_val = '0;
    endcase
  end

  lcd_phase_timer #(.W(TIMER_W)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .clk_en   (bus.clk_en),
    .load     (t_load),
    .load_val (t_val),
    .zero     (t_zero)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      poll_cnt <= '0;
      poll_q   <= 1'b0;
      rs_q     <= 1'b0;
      res_q    <= '0;
      en_q     <= 1'b0;
      rw_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (bus.clk_en) begin
      state  <= next_state;
      en_q   <= (next_state == S_PULSE);
      rw_q   <= (next_state != S_IDLE) && (next_state != S_DONE);
      busy_q <= (next_state != S_IDLE) && (next_state != S_DONE);
      done_q <= (next_state == S_DONE);
      if (state == S_IDLE && bus.start) begin
        rs_q               <= bus.dataa[ARG_RS];
        poll_q             <= bus.dataa[ARG_POLL] & ~bus.dataa[ARG_RS];
        poll_cnt           <= '0;
        res_q[RES_TIMEOUT] <= 1'b0;
      end
      // Single sample per pulse, taken while en is still high
      if (last_pulse) begin
        res_q[RES_BYTE +: 8] <= bus.lcd_data_in;
        if (poll_cnt != POLL_LIM)
          poll_cnt <= poll_cnt + CW'(1);
      end
      if (state == S_HOLD && t_zero && poll_q && res_q[RES_BYTE+7] && poll_cnt == POLL_LIM)
        res_q[RES_TIMEOUT] <= 1'b1;
    end
  end

  assign bus.en     = en_q;
  assign bus.rw     = rw_q;
  assign bus.rs     = rs_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = {23'b0, res_q};

endmodule
